// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle sequencer for the MIPS core.
// Each instruction steps through FETCH -> DECODE -> EXEC -> (MEM) -> WB. The block drives the
// PC, IR, register-file and memory strobes. It stalls on the imem/dmem ready handshakes. It
// halts on syscall, on a reserved instruction, or when a memory wait times out, and it reports
// the cause on exc_code.
//
// Optional feature: define MIPS_CTRL_PERF_EN to add the perf_cycles/perf_retired counters.
//
// Ports:
//   clk, rst_b              core clock, asynchronous active-low reset
//   imem_req / imem_ready   instruction fetch handshake; ir_we latches IR (Mealy on imem_ready)
//   dcd_we/sys/ri/load/store decoder controls, sampled in DECODE only
//   dmem_req/dmem_wr/dmem_ready data access handshake (dmem_wr = 1 for a store)
//   rf_we, pc_we            one-cycle write strobes in WB
//   halted, exc_code        sticky halt and its cause (0 none, 1 sys, 2 RI, 3 bus timeout)
//   state                   debug view of the sequencer state
//   perf_cycles/perf_retired (MIPS_CTRL_PERF_EN only) free-running performance counters
module mips_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic             dcd_we,
  input  logic             dcd_sys,
  input  logic             dcd_ri,
  input  logic             dcd_load,
  input  logic             dcd_store,
  output logic             dmem_req,
  output logic             dmem_wr,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halted,
  output logic [1:0]       exc_code,
`ifdef MIPS_CTRL_PERF_EN
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_retired,
`endif
  output logic [2:0]       state
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_SYS  = 2'd1;
  localparam logic [1:0] EXC_RI   = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;

  // Reject parameter values the 8-bit wait counter or the perf counters cannot support.
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("mips_mc_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]        exc_q, exc_d;
  logic              we_q, we_d;
  logic              load_q, load_d;
  logic              store_q, store_d;

  // State and latched decode registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
      exc_q      <= EXC_NONE;
      we_q       <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      exc_q      <= exc_d;
      we_q       <= we_d;
      load_q     <= load_d;
      store_q    <= store_d;
    end
  end

  // Next-state logic. A wait cycle only counts as a timeout once wait_cnt has already
  // reached the limit, so a ready that arrives in that same cycle still completes normally.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    exc_d      = exc_q;
    we_d       = we_q;
    load_d     = load_q;
    store_d    = store_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_cnt_q >= WAIT_LIM) begin
          state_d = ST_HALT;
          exc_d   = EXC_BUS;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        we_d    = dcd_we;
        load_d  = dcd_load;
        store_d = dcd_store;
        if (dcd_sys) begin
          state_d = ST_HALT;
          exc_d   = EXC_SYS;
        end else if (dcd_ri) begin
          state_d = ST_HALT;
          exc_d   = EXC_RI;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (load_q || store_q) begin
          state_d    = ST_MEM;
          wait_cnt_d = '0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_d = ST_WB;
        end else if (wait_cnt_q >= WAIT_LIM) begin
          state_d = ST_HALT;
          exc_d   = EXC_BUS;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        state_d    = ST_FETCH;
        wait_cnt_d = '0;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d    = ST_FETCH;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Moore strobes decoded from the registered state. ir_we is the only Mealy term.
  // imem_req is qualified with rst_b so that no strobe is seen while reset is held.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_wr  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imem_req = rst_b;
        ir_we    = rst_b & imem_ready;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_wr  = store_q;
      end
      ST_WB: begin
        pc_we = 1'b1;
        rf_we = we_q & ~store_q;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign exc_code = exc_q;
  assign state    = state_q;

`ifdef MIPS_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_cycles_q;
  logic [CNT_W-1:0] perf_retired_q;

  // Performance counters; both wrap naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      perf_cycles_q  <= '0;
      perf_retired_q <= '0;
    end else begin
      if (state_q != ST_HALT) perf_cycles_q <= perf_cycles_q + CNT_W'(1);
      if (pc_we)              perf_retired_q <= perf_retired_q + CNT_W'(1);
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: each stimulus cycle pushes the hand-computed outputs
// for that cycle; a monitor pops and compares them on the falling edge.
module tb_mips_mc_ctrl;

  localparam int unsigned CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       imem_req, imem_ready, ir_we;
  logic       dcd_we, dcd_sys, dcd_ri, dcd_load, dcd_store;
  logic       dmem_req, dmem_wr, dmem_ready;
  logic       rf_we, pc_we, halted;
  logic [1:0] exc_code;
  logic [2:0] state;
`ifdef MIPS_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_cycles, perf_retired;
`endif

  mips_mc_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_b(rst_b),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dcd_we(dcd_we), .dcd_sys(dcd_sys), .dcd_ri(dcd_ri),
    .dcd_load(dcd_load), .dcd_store(dcd_store),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .exc_code(exc_code),
`ifdef MIPS_CTRL_PERF_EN
    .perf_cycles(perf_cycles), .perf_retired(perf_retired),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  // Expected output vector: state, {imem_req, ir_we, dmem_req, dmem_wr, rf_we, pc_we, halted}, exc
  typedef struct packed {
    logic [2:0] st;
    logic [6:0] f;
    logic [1:0] exc;
  } exp_t;

  localparam exp_t E_RST    = '{3'd0, 7'b0000000, 2'd0};
  localparam exp_t E_F_WAIT = '{3'd0, 7'b1000000, 2'd0};
  localparam exp_t E_F_GO   = '{3'd0, 7'b1100000, 2'd0};
  localparam exp_t E_DEC    = '{3'd1, 7'b0000000, 2'd0};
  localparam exp_t E_EXE    = '{3'd2, 7'b0000000, 2'd0};
  localparam exp_t E_MEM_RD = '{3'd3, 7'b0010000, 2'd0};
  localparam exp_t E_MEM_WR = '{3'd3, 7'b0011000, 2'd0};
  localparam exp_t E_WB_RF  = '{3'd4, 7'b0000110, 2'd0};
  localparam exp_t E_WB     = '{3'd4, 7'b0000010, 2'd0};
  localparam exp_t E_H_SYS  = '{3'd5, 7'b0000001, 2'd1};
  localparam exp_t E_H_RI   = '{3'd5, 7'b0000001, 2'd2};
  localparam exp_t E_H_BUS  = '{3'd5, 7'b0000001, 2'd3};

  // Input vector bits: {rst_b, imem_ready, dmem_ready, we, sys, ri, load, store}
  localparam logic [7:0] I_IDLE  = 8'b1000_0000;
  localparam logic [7:0] I_IRDY  = 8'b1100_0000;
  localparam logic [7:0] I_DRDY  = 8'b1010_0000;
  localparam logic [7:0] I_RST   = 8'b0000_0000;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one cycle of inputs just after the rising edge and queue the expected outputs.
  task automatic step(input logic [7:0] in, input exp_t e);
    @(posedge clk);
    #1;
    rst_b      = in[7];
    imem_ready = in[6];
    dmem_ready = in[5];
    dcd_we     = in[4];
    dcd_sys    = in[3];
    dcd_ri     = in[2];
    dcd_load   = in[1];
    dcd_store  = in[0];
    sb.push_back(e);
  endtask

  task automatic step_n(input int n, input logic [7:0] in, input exp_t e);
    for (int i = 0; i < n; i++) step(in, e);
  endtask

  // Monitor: compare the DUT outputs of this cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      exp_t got;
      e   = sb.pop_front();
      got = '{state, {imem_req, ir_we, dmem_req, dmem_wr, rf_we, pc_we, halted}, exc_code};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL cycle_check#%0d t=%0t: got st=%0d f=%b exc=%0d, want st=%0d f=%b exc=%0d",
                 total, $time, got.st, got.f, got.exc, e.st, e.f, e.exc);
      end
    end
  end

  initial begin
    imem_ready = 1'b0; dmem_ready = 1'b0;
    dcd_we = 1'b0; dcd_sys = 1'b0; dcd_ri = 1'b0; dcd_load = 1'b0; dcd_store = 1'b0;

    // Reset state
    step(I_RST, E_RST);

    // ADD, everything ready at once; junk on dcd_* during EXEC must be ignored
    step(I_IRDY, E_F_GO);
    step(8'b1001_0000, E_DEC);
    step(8'b1000_1001, E_EXE);
    step(I_IRDY, E_WB_RF);

    // Load with three dmem waits: 8 cycles total
    step(I_IRDY, E_F_GO);
    step(8'b1001_0010, E_DEC);
    step(I_IDLE, E_EXE);
    step_n(3, I_IDLE, E_MEM_RD);
    step(I_DRDY, E_MEM_RD);
    step(I_IDLE, E_WB_RF);

    // Store with immediate ready: dmem_wr in MEM, no rf_we
    step(I_IRDY, E_F_GO);
    step(8'b1001_0001, E_DEC);
    step(I_IDLE, E_EXE);
    step(I_DRDY, E_MEM_WR);
    step(I_IDLE, E_WB);

    // Load and store together behave as a store
    step(I_IRDY, E_F_GO);
    step(8'b1001_0011, E_DEC);
    step(I_IDLE, E_EXE);
    step(I_DRDY, E_MEM_WR);
    step(I_IDLE, E_WB);

    // imem_ready arriving on the limit cycle (wait count 15) still completes normally
    step_n(15, I_IDLE, E_F_WAIT);
    step(I_IRDY, E_F_GO);
    step(I_IDLE, E_DEC);
    step(I_IDLE, E_EXE);
    step(I_IDLE, E_WB);

    // syscall and RI together: syscall wins, halt is sticky with no strobes
    step(I_IRDY, E_F_GO);
    step(8'b1001_1100, E_DEC);
    step_n(3, 8'b1110_0000, E_H_SYS);

    // Reset clears the halt; reserved instruction
    step(I_RST, E_RST);
    step(I_IRDY, E_F_GO);
    step(8'b1000_0100, E_DEC);
    step_n(2, I_IRDY, E_H_RI);

    // Fetch timeout: 16 fetch cycles without ready, then bus error; late ready ignored
    step(I_RST, E_RST);
    step_n(16, I_IDLE, E_F_WAIT);
    step_n(2, I_IRDY, E_H_BUS);

    // Data timeout on a load: no rf_we/pc_we for the halted instruction
    step(I_RST, E_RST);
    step(I_IRDY, E_F_GO);
    step(8'b1001_0010, E_DEC);
    step(I_IDLE, E_EXE);
    step_n(16, I_IDLE, E_MEM_RD);
    step_n(2, I_DRDY, E_H_BUS);

    // Reset in the middle of a store wait, then a normal ADD
    step(I_RST, E_RST);
    step(I_IRDY, E_F_GO);
    step(8'b1001_0001, E_DEC);
    step(I_IDLE, E_EXE);
    step_n(2, I_IDLE, E_MEM_WR);
    step(I_RST, E_RST);
    step(I_IDLE, E_F_WAIT);
    step(I_IRDY, E_F_GO);
    step(8'b1001_0000, E_DEC);
    step(I_IDLE, E_EXE);
    step(I_IDLE, E_WB_RF);

    // Let the monitor drain the last entry; any leftover counts as a failure
    repeat (2) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
